// File: rtl/classify_pkg.sv
// Shared types and constants for the green-object classification sequencer:
// FSM states, result codes and the per-channel green window.
package classify_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SCAN   = 3'd3,
    ST_DECIDE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [1:0] RES_NONE  = 2'b00;
  localparam logic [1:0] RES_LEFT  = 2'b01;
  localparam logic [1:0] RES_SHAPE = 2'b10;

  // Bounds are 9 bits wide so an upper bound of 255 is an ordinary compare.
  localparam logic [8:0] LO0 = 9'd18;
  localparam logic [8:0] HI0 = 9'd43;
  localparam logic [8:0] LO1 = 9'd25;
  localparam logic [8:0] HI1 = 9'd255;
  localparam logic [8:0] LO2 = 9'd25;
  localparam logic [8:0] HI2 = 9'd255;

  function automatic logic in_range(input logic [7:0] v, input logic [8:0] lo,
                                    input logic [8:0] hi);
    return ({1'b0, v} >= lo) && ({1'b0, v} <= hi);
  endfunction

  function automatic logic is_green(input logic [7:0] c0, input logic [7:0] c1,
                                    input logic [7:0] c2);
    return in_range(c0, LO0, HI0) && in_range(c1, LO1, HI1) && in_range(c2, LO2, HI2);
  endfunction

endpackage

// File: rtl/green_pixel_test.sv
// Collects the byte stream of one pixel and, on the ch2 byte, presents the
// green decision together with the pixel's row/column.
module green_pixel_test
  import classify_pkg::*;
#(
  parameter int WIDTH  = 30,
  parameter int HEIGHT = 20,
  parameter int DEPTH  = 3,
  parameter int COL_W  = 5,
  parameter int ROW_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [7:0]       i_data,
  output logic             o_valid,
  output logic             o_green,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col
);

  localparam int CH_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CH_W-1:0]  r_ch;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [7:0]       r_ch0;
  logic [7:0]       r_ch1;
  logic             w_last_ch;

  assign w_last_ch = (r_ch == CH_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch  <= '0;
      r_col <= '0;
      r_row <= '0;
      r_ch0 <= '0;
      r_ch1 <= '0;
    end else if (i_clr) begin
      r_ch  <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (i_valid) begin
      if (r_ch == CH_W'(0)) r_ch0 <= i_data;
      if (r_ch == CH_W'(1)) r_ch1 <= i_data;
      if (w_last_ch) begin
        r_ch <= '0;
        if (r_col == COL_W'(WIDTH - 1)) begin
          r_col <= '0;
          r_row <= (r_row == ROW_W'(HEIGHT - 1)) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end else begin
        r_ch <= r_ch + CH_W'(1);
      end
    end
  end

  // ch2 is judged straight off the read port so the mask write lands on its capture edge.
  assign o_valid = i_valid && w_last_ch;
  assign o_green = is_green(r_ch0, r_ch1, i_data);
  assign o_row   = r_row;
  assign o_col   = r_col;

endmodule

// File: rtl/classify_sequencer.sv
// Reads the RGB frame buffer, builds a green mask and classifies it into a 2-bit
// result. Optional stat_* outputs are enabled by defining CLASSIFY_STATS_EN.
module classify_sequencer
  import classify_pkg::*;
#(
  parameter int HEIGHT       = 20,
  parameter int WIDTH        = 30,
  parameter int DEPTH        = 3,
  parameter int LEFT_COLS    = 12,
  parameter int SHIFT        = 2,
  parameter int LEFT_THRESH  = 120,
  parameter int TRANS_TARGET = 4
) (
  input  logic        fpga_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        img_ready,
  output logic        rd_en,
  output logic [10:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        done,
  output logic [1:0]  result
`ifdef CLASSIFY_STATS_EN
  ,
  output logic [9:0]  stat_total,
  output logic [9:0]  stat_left,
  output logic [4:0]  stat_leftmost,
  output logic [4:0]  stat_trans
`endif
);

  localparam int N     = HEIGHT * WIDTH * DEPTH;
  localparam int COL_W = $clog2(WIDTH + 1);
  localparam int ROW_W = $clog2(HEIGHT);

  state_t           r_state;
  logic             r_rd_en;
  logic             r_rd_en_d;
  logic [10:0]      r_rd_addr;
  logic             r_busy;
  logic             r_done;
  logic [1:0]       r_result;
  logic [9:0]       r_total;
  logic [9:0]       r_left;
  logic [COL_W-1:0] r_leftmost;
  logic [4:0]       r_trans;
  logic [ROW_W-1:0] r_scan_row;
  logic [WIDTH-1:0] r_mask [HEIGHT];

  logic             w_accept;
  logic             w_pix_valid;
  logic             w_pix_green;
  logic [ROW_W-1:0] w_pix_row;
  logic [COL_W-1:0] w_pix_col;
  logic [WIDTH-1:0]   w_scan_row;
  logic [2*WIDTH-1:0] w_row_pad;
  logic [COL_W:0]     w_idx_a;
  logic [COL_W:0]     w_idx_b;
  logic               w_diff;

  assign w_accept = (r_state == ST_IDLE) && start && img_ready;

  green_pixel_test #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .DEPTH (DEPTH),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_green (
    .clk    (fpga_clk),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_valid(r_rd_en_d),
    .i_data (rd_data),
    .o_valid(w_pix_valid),
    .o_green(w_pix_green),
    .o_row  (w_pix_row),
    .o_col  (w_pix_col)
  );

  // Zero padding above WIDTH makes leftmost+SHIFT past the edge read as 0.
  assign w_scan_row = r_mask[r_scan_row];
  assign w_row_pad  = {{WIDTH{1'b0}}, w_scan_row};
  assign w_idx_a    = {1'b0, r_leftmost};
  assign w_idx_b    = w_idx_a + (COL_W + 1)'(SHIFT);
  assign w_diff     = (r_leftmost != COL_W'(WIDTH)) && (w_row_pad[w_idx_a] != w_row_pad[w_idx_b]);

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < HEIGHT; r++) r_mask[r] <= '0;
    end else if (w_pix_valid) begin
      r_mask[w_pix_row][w_pix_col] <= w_pix_green;
    end
  end

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rd_en    <= 1'b0;
      r_rd_en_d  <= 1'b0;
      r_rd_addr  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= RES_NONE;
      r_total    <= '0;
      r_left     <= '0;
      r_leftmost <= COL_W'(WIDTH);
      r_trans    <= '0;
      r_scan_row <= '0;
    end else begin
      r_rd_en_d <= r_rd_en;
      r_done    <= 1'b0;

      if (w_pix_valid && w_pix_green) begin
        r_total <= r_total + 10'd1;
        if (w_pix_col < COL_W'(LEFT_COLS)) r_left <= r_left + 10'd1;
        if (w_pix_col < r_leftmost) r_leftmost <= w_pix_col;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_READ;
            r_busy     <= 1'b1;
            r_rd_en    <= 1'b1;
            r_rd_addr  <= '0;
            r_total    <= '0;
            r_left     <= '0;
            r_leftmost <= COL_W'(WIDTH);
            r_trans    <= '0;
            r_scan_row <= '0;
          end
        end
        ST_READ: begin
          if (r_rd_addr == 11'(N - 1)) begin
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_state   <= ST_DRAIN;
          end else begin
            r_rd_addr <= r_rd_addr + 11'd1;
          end
        end
        ST_DRAIN: r_state <= ST_SCAN;
        ST_SCAN: begin
          r_trans <= r_trans + {4'd0, w_diff};
          if (r_scan_row == ROW_W'(HEIGHT - 3)) begin
            r_scan_row <= '0;
            r_state    <= ST_DECIDE;
          end else begin
            r_scan_row <= r_scan_row + ROW_W'(1);
          end
        end
        ST_DECIDE: begin
          if (r_trans == 5'(TRANS_TARGET))     r_result <= RES_SHAPE;
          else if (r_left > 10'(LEFT_THRESH))  r_result <= RES_LEFT;
          else                                 r_result <= RES_NONE;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_en   = r_rd_en;
  assign rd_addr = r_rd_addr;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;

`ifdef CLASSIFY_STATS_EN
  logic [9:0] r_stat_total;
  logic [9:0] r_stat_left;
  logic [4:0] r_stat_leftmost;
  logic [4:0] r_stat_trans;

  always_ff @(posedge fpga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_total    <= '0;
      r_stat_left     <= '0;
      r_stat_leftmost <= '0;
      r_stat_trans    <= '0;
    end else if (r_state == ST_DECIDE) begin
      r_stat_total    <= r_total;
      r_stat_left     <= r_left;
      r_stat_leftmost <= 5'(r_leftmost);
      r_stat_trans    <= r_trans;
    end
  end

  assign stat_total    = r_stat_total;
  assign stat_left     = r_stat_left;
  assign stat_leftmost = r_stat_leftmost;
  assign stat_trans    = r_stat_trans;
`endif

endmodule

// File: tb/tb_classify_sequencer.sv
// Directed and randomized frames for classify_sequencer, checked against a
// pixel-level reference classifier computed from the frame contents.
module tb_classify_sequencer;

  localparam int H = 20;
  localparam int W = 30;
  localparam int D = 3;
  localparam int N = H * W * D;
  localparam int LATENCY = 1821;

  logic        fpga_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        img_ready = 1'b0;
  logic        rd_en;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data = 8'd0;
  logic        busy;
  logic        done;
  logic [1:0]  result;
`ifdef CLASSIFY_STATS_EN
  logic [9:0]  stat_total;
  logic [9:0]  stat_left;
  logic [4:0]  stat_leftmost;
  logic [4:0]  stat_trans;
`endif

  logic [7:0] mem [N];
  int n_vec = 0;
  int n_fail = 0;
  int done_cnt = 0;

  classify_sequencer dut (
    .fpga_clk (fpga_clk),
    .rst_n    (rst_n),
    .start    (start),
    .img_ready(img_ready),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .busy     (busy),
    .done     (done),
    .result   (result)
`ifdef CLASSIFY_STATS_EN
    ,
    .stat_total   (stat_total),
    .stat_left    (stat_left),
    .stat_leftmost(stat_leftmost),
    .stat_trans   (stat_trans)
`endif
  );

  always #5 fpga_clk = ~fpga_clk;

  always @(posedge fpga_clk) begin
    if (rd_en === 1'b1 && rd_addr < 11'(N)) rd_data <= mem[rd_addr];
  end

  always @(posedge fpga_clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int i = 0; i < N; i++) mem[i] = 8'd0;
  endtask

  task automatic set_px(input int r, input int c, input int c0, input int c1, input int c2);
    mem[(r * W + c) * D + 0] = 8'(c0);
    mem[(r * W + c) * D + 1] = 8'(c1);
    mem[(r * W + c) * D + 2] = 8'(c2);
  endtask

  // Reference: classify the frame directly from the pixel rules.
  task automatic model(output logic [1:0] res, output int tot, output int lft,
                       output int lm, output int tr);
    bit m [H][W];
    int a, b;
    tot = 0; lft = 0; lm = W; tr = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int base;
        base = (r * W + c) * D;
        m[r][c] = (mem[base] >= 18 && mem[base] <= 43 && mem[base+1] >= 25 && mem[base+2] >= 25);
        if (m[r][c]) begin
          tot++;
          if (c < 12) lft++;
          if (c < lm) lm = c;
        end
      end
    end
    if (lm < W) begin
      for (int r = 0; r <= H - 3; r++) begin
        a = m[r][lm];
        b = (lm + 2 < W) ? m[r][lm + 2] : 0;
        if (a != b) tr++;
      end
    end
    if (tr == 4)        res = 2'b10;
    else if (lft > 120) res = 2'b01;
    else                res = 2'b00;
  endtask

  task automatic run_frame(input string name, input int plan_res, input bit extra_start);
    logic [1:0] er;
    int et, el, elm, etr, cyc, d0;
    bit found;
    model(er, et, el, elm, etr);
    d0 = done_cnt;
    @(negedge fpga_clk);
    img_ready = 1'b1;
    start = 1'b1;
    @(posedge fpga_clk);
    #1;
    start = 1'b0;
    check({name, "/busy_accept"}, busy, 1);
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 3000) begin
      start = (extra_start && cyc == 100) ? 1'b1 : 1'b0;
      @(posedge fpga_clk);
      #1;
      cyc++;
      if (done === 1'b1) found = 1'b1;
    end
    start = 1'b0;
    check({name, "/done_seen"}, found, 1);
    check({name, "/latency"}, cyc, LATENCY);
    check({name, "/result"}, result, er);
    if (plan_res >= 0) check({name, "/plan_result"}, result, plan_res);
    check({name, "/busy_at_done"}, busy, 0);
`ifdef CLASSIFY_STATS_EN
    check({name, "/stat_total"}, stat_total, et);
    check({name, "/stat_left"}, stat_left, el);
    check({name, "/stat_leftmost"}, stat_leftmost, elm);
    check({name, "/stat_trans"}, stat_trans, etr);
`endif
    @(posedge fpga_clk);
    #1;
    check({name, "/done_pulse"}, done, 0);
    check({name, "/done_count"}, done_cnt - d0, 1);
    $display("run %s: result=%0d model=%0d total=%0d left=%0d leftmost=%0d trans=%0d cycles=%0d",
             name, result, er, et, el, elm, etr, cyc);
  endtask

  initial begin
    int vals [8][3];
    int dens [4];
    int cyc, d0;
    clear_frame();

    repeat (3) @(posedge fpga_clk);
    #1;
    check("reset/busy", busy, 0);
    check("reset/done", done, 0);
    check("reset/rd_en", rd_en, 0);
    check("reset/rd_addr", rd_addr, 0);
    check("reset/result", result, 0);
    @(negedge fpga_clk);
    rst_n = 1'b1;

    // start without img_ready must not launch, and must not be queued
    @(negedge fpga_clk);
    img_ready = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge fpga_clk);
    #1;
    check("noready/busy", busy, 0);
    check("noready/rd_en", rd_en, 0);
    start = 1'b0;
    img_ready = 1'b1;
    repeat (3) @(posedge fpga_clk);
    #1;
    check("noready/no_queue", busy, 0);
    $display("run noready: busy=%0d rd_en=%0d", busy, rd_en);

    clear_frame();
    run_frame("all_zero", 0, 1'b0);

    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) set_px(r, c, 30, 100, 100);
    run_frame("all_green_dup_start", 1, 1'b1);

    clear_frame();
    foreach (vals[i]) ;
    set_px(2, 5, 30, 100, 100); set_px(3, 5, 30, 100, 100);
    set_px(6, 5, 30, 100, 100); set_px(7, 5, 30, 100, 100);
    run_frame("shape_col5", 2, 1'b0);

    clear_frame();
    set_px(4, 29, 30, 100, 100); set_px(19, 29, 30, 100, 100);
    run_frame("edge_col29", 0, 1'b0);

    vals = '{'{17, 100, 100}, '{44, 100, 100}, '{18, 100, 100}, '{43, 100, 100},
             '{30, 24, 100}, '{30, 25, 100}, '{30, 100, 24}, '{30, 255, 255}};
    for (int k = 0; k < 8; k++) begin
      clear_frame();
      set_px(2, 5, 30, 100, 100); set_px(3, 5, 30, 100, 100); set_px(6, 5, 30, 100, 100);
      set_px(7, 5, vals[k][0], vals[k][1], vals[k][2]);
      run_frame($sformatf("bound_%0d_%0d_%0d", vals[k][0], vals[k][1], vals[k][2]),
                (k == 2 || k == 3 || k == 5 || k == 7) ? 2 : 0, 1'b0);
    end

    clear_frame();
    for (int r = 0; r < 10; r++) for (int c = 0; c < 12; c++) set_px(r, c, 30, 100, 100);
    run_frame("left_120", 0, 1'b0);
    set_px(10, 0, 30, 100, 100);
    run_frame("left_121", 1, 1'b0);

    // abort mid-run: result from left_121 must be cleared and no done may appear
    @(negedge fpga_clk);
    start = 1'b1;
    img_ready = 1'b1;
    @(posedge fpga_clk);
    #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 900) begin
      @(posedge fpga_clk);
      #1;
      cyc++;
    end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("abort/busy", busy, 0);
    check("abort/result", result, 0);
    check("abort/rd_en", rd_en, 0);
    check("abort/done", done, 0);
    repeat (2) @(posedge fpga_clk);
    @(negedge fpga_clk);
    rst_n = 1'b1;
    repeat (2000) @(posedge fpga_clk);
    #1;
    check("abort/no_done", done_cnt - d0, 0);
    check("abort/idle", busy, 0);
    $display("run abort: busy=%0d result=%0d dones=%0d", busy, result, done_cnt - d0);

    clear_frame();
    set_px(2, 5, 30, 100, 100); set_px(3, 5, 30, 100, 100);
    set_px(6, 5, 30, 100, 100); set_px(7, 5, 30, 100, 100);
    run_frame("after_abort", 2, 1'b0);

    dens = '{3, 30, 60, 95};
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < H; r++) begin
        for (int c = 0; c < W; c++) begin
          if ($urandom_range(0, 99) < dens[f])
            set_px(r, c, $urandom_range(18, 43), $urandom_range(25, 255), $urandom_range(25, 255));
          else
            set_px(r, c, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end
      end
      run_frame($sformatf("random_d%0d", dens[f]), -1, 1'b0);
    end

    // random sparse shapes near a random column exercise the transition count
    for (int f = 0; f < 3; f++) begin
      int lmc;
      clear_frame();
      lmc = $urandom_range(0, 29);
      for (int r = 0; r < H; r++) begin
        if ($urandom_range(0, 3) == 0) set_px(r, lmc, 30, 100, 100);
        if (lmc + 2 < W && $urandom_range(0, 3) == 0) set_px(r, lmc + 2, 30, 100, 100);
      end
      run_frame($sformatf("random_shape_%0d", lmc), -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/classify_sequencer.md
Name: classify_sequencer

Overview:
- Sequences green-object classification over the stored RGB frame buffer (HEIGHT x WIDTH x DEPTH bytes, index = (row*WIDTH+col)*DEPTH+ch) once the Pi capture path has filled it.
- Reads the buffer byte-serially through a 1-cycle-latency read port and thresholds each pixel into a 1-bit green mask.
- Accumulates total and left-region counts and the leftmost green column, then scans for transitions.
- Emits a 2-bit class with a start/done handshake. Sits between the frame buffer and the LED/result logic.

Parameters:
- HEIGHT, 20, image rows
- WIDTH, 30, image columns
- DEPTH, 3, bytes per pixel (ch0..ch2)
- LEFT_COLS, 12, columns counted as left region (col < LEFT_COLS)
- SHIFT, 2, column offset for transition scan
- LEFT_THRESH, 120, left-count threshold for class 01
- TRANS_TARGET, 4, transition count for class 10

Ports:
- fpga_clk  in  1  system clock
- rst_n  in  1  async active-low reset
- start  in  1  request classification; sampled only in IDLE when img_ready=1
- img_ready  in  1  frame buffer full
- rd_en  out  1  read strobe
- rd_addr  out  11  byte address, 0..HEIGHT*WIDTH*DEPTH-1
- rd_data  in  8  byte returned the cycle after rd_en
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse, result valid
- result  out  2  00 none, 01 left-heavy, 10 target shape

Behaviour:
- Reset (async, rst_n=0): state IDLE; rd_en=0, rd_addr=0, busy=0, done=0, result=00, all counters and the mask cleared. Reset mid-run aborts with no done.
- IDLE: start & img_ready moves to READ, busy=1. start while busy or with img_ready=0 is ignored (no queuing).
- READ: rd_en=1, rd_addr increments 0..N-1 (N=HEIGHT*WIDTH*DEPTH=1800), one per cycle. After addr N-1 go to DRAIN.
- Data capture: rd_data is captured one cycle after its address. The channel counter cycles 0..DEPTH-1.
- Green test: a pixel is green iff ch0 in [18,43], ch1 in [25,255] and ch2 in [25,255], all inclusive and unsigned. The test is evaluated on capture of ch2.
- Mask update: mask[row][col] is written for every pixel.
- total_cnt (10b) increments for each green pixel. left_cnt (10b) increments if col < LEFT_COLS.
- leftmost (5b) starts at WIDTH (meaning none) and is set to min(leftmost, col) for each green pixel.
- DRAIN: one cycle, rd_en=0, consumes the last byte, then go to SCAN.
- SCAN: rows r=0..HEIGHT-3 (18 cycles). trans increments when mask[r][leftmost] != mask[r][leftmost+SHIFT].
- SCAN out-of-range: a column >= WIDTH reads as 0. If leftmost==WIDTH, no comparisons are made and trans stays 0.
- DECIDE: result = 10 if trans==TRANS_TARGET; else 01 if left_cnt > LEFT_THRESH (strict); else 00. Then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Latency: done asserts exactly N+HEIGHT+1 cycles (1821 at defaults) after the start-accept edge.
- result holds until the next DECIDE or reset.
- Counter widths saturate-free: maximum values are 600 and 18.

Optional Feature:
- Macro CLASSIFY_STATS_EN.
- Defined: adds outputs stat_total[9:0], stat_left[9:0], stat_leftmost[4:0] and stat_trans[4:0]. These are registered at DECIDE, held until the next DECIDE, and reset to 0.
- Undefined: these ports and registers do not exist. Core behaviour is identical.

Decomposition:
- Package classify_pkg holds:
  - state enum (IDLE, READ, DRAIN, SCAN, DECIDE, DONE);
  - result codes RES_NONE=2'b00, RES_LEFT=2'b01, RES_SHAPE=2'b10;
  - green bound constants (LO0=18, HI0=43, LO1=25, HI1=255, LO2=25, HI2=255).
- Sub-module green_pixel_test: registers ch0/ch1 and outputs a valid mask bit with row/col on ch2 capture.

Test Plan:
- All-zero frame, start -> done at cycle 1821, result=00, leftmost=WIDTH, trans=0.
- Every pixel (30,100,100), start -> result=01: left_cnt=240 > 120, trans=0 because columns lm=0 and 2 are both all green.
- Green only at rows 2,3 and 6,7, column 5 (col 7 never green) -> leftmost=5, trans=4, result=10.
- Only green pixel at col 29 -> leftmost=29; col 31 is out of range and reads 0; rows containing it give trans=1; result=00.
- Boundaries: ch0=17 or 44 is not green, ch0=18 or 43 is green; ch1=24 is not green.
- Handshake and reset:
  - start with img_ready=0 -> no busy;
  - second start pulse during READ -> ignored, single done;
  - rst_n low at cycle 900 -> busy=0, result=00, no done, next run is clean.
